sram_req_arbiter: RTL and testbench
===================================

// Module: sram_req_arbiter
// PURPOSE
//   Shares one SRAM-like memory port between the IF fetch requester (inst_*) and the EXE/MEM load-store
//   requester (data_*). Data side wins by default; an anti-starvation counter guarantees fetch progress.
//   Tracks outstanding accepted requests in order and routes each slave data_ok/rdata back to its owner.
//   Sits between the pipeline stages and the SRAM-like-to-AXI bridge.
// PARAMETERS
//   DEPTH      4   max accepted-but-not-returned requests (power of 2, >=2)
//   STARVE_LIM 8   consecutive cycles of inst waiting while data is granted before inst is forced (>=1)
// PORTS
//   clk              in   1   clock
//   resetn           in   1   reset, synchronous, active-low
//   inst_req/wr      in   1   fetch request / write flag;  inst_size in 2; inst_wstrb in 4
//   inst_addr/wdata  in   32  fetch address / write data
//   inst_addr_ok     out  1   fetch request accepted this cycle
//   inst_data_ok     out  1   fetch response valid this cycle;  inst_rdata out 32
//   data_req/wr      in   1   load/store request / write flag;  data_size in 2; data_wstrb in 4
//   data_addr/wdata  in   32  load/store address / store data
//   data_addr_ok     out  1   load/store accepted;  data_data_ok out 1;  data_rdata out 32
//   mem_req/wr       out  1   to slave: request / write;  mem_size out 2; mem_wstrb out 4
//   mem_addr/wdata   out  32  to slave: address / write data
//   mem_addr_ok      in   1   slave accepted;  mem_data_ok in 1;  mem_rdata in 32
//   proto_err        out  1   sticky: mem_data_ok seen with no outstanding request
// BEHAVIOUR
//   Reset (resetn=0 at posedge): FIFO empty, count=0, lock=0, starve_cnt=0, proto_err=0. All outputs 0
//     during and after reset until a requester asserts req.
//   Grant (comb): if lock -> locked owner; else if data_req & ~force_inst -> DATA; else if inst_req -> INST;
//     else DATA. force_inst = inst_req & (starve_cnt == STARVE_LIM).
//   mem_* = granted side's fields; mem_req = granted_req & ~full. full = (count == DEPTH).
//   Accept = mem_req & mem_addr_ok. Owner's addr_ok = accept; other side's addr_ok = 0. Zero latency.
//   Lock: set when mem_req & ~mem_addr_ok (grant held stable while slave stalls); cleared on accept or if
//     locked owner drops req (withdrawal allowed; IF withdraws on cancel).
//   Starvation: starve_cnt++ (saturate at STARVE_LIM) each cycle inst_req=1 and inst not accepted;
//     cleared to 0 on inst accept or inst_req=0.
//   Order FIFO: 1-bit owner tag (0=INST,1=DATA) pushed on accept, popped on mem_data_ok.
//     Response: tag at head selects inst_data_ok or data_data_ok = mem_data_ok, same cycle; both
//     inst_rdata and data_rdata = mem_rdata. Writes also return data_ok (SRAM-like), popped the same way.
//   Boundaries:
//     full: mem_req=0, no addr_ok; push blocked even if pop in same cycle (pop frees slot next cycle).
//     empty & mem_data_ok: no data_ok to either side, count stays 0, proto_err<=1 (sticky until reset).
//     push & pop same cycle (not full): count unchanged, pointers both advance; wrap modulo DEPTH.
//     accept & data_ok to same owner same cycle: response belongs to the older request (head).
//     reset mid-operation: outstanding tags discarded; late slave data_ok after reset -> proto_err.
//   count width $clog2(DEPTH)+1; pointers $clog2(DEPTH), natural wrap.
// STRUCTURE
//   Shared package/header (mycpu.h): `MST_INST 1'b0, `MST_DATA 1'b1, SRAM-like field widths.
//   Sub-module order_fifo (DEPTH x 1-bit, push/pop/full/empty/head); arbitration, lock, starvation
//   counter and routing stay in sram_req_arbiter.
// TESTING
//   1. inst_req only, addr 0x1c000000, slave addr_ok immediate, data_ok +2 cycles rdata 0x02800000 ->
//      inst_addr_ok cycle0, inst_data_ok cycle2 with that rdata; data_data_ok never asserts.
//   2. inst_req & data_req same cycle -> data accepted first; inst accepted next cycle; responses returned
//      D then I routed correctly with distinct rdata 0xAAAA0000/0x55550000.
//   3. data_req held continuously, inst_req held, slave always ready -> inst accepted exactly on cycle 9
//      (STARVE_LIM=8), starve_cnt back to 0.
//   4. Slave withholds data_ok; issue 5 requests -> 4 accepted, mem_req=0 on 5th; one data_ok -> 5th
//      accepted the following cycle, not the same cycle.
//   5. mem_addr_ok=0 for 3 cycles while data stalls, inst_req rises meanwhile -> mem_addr/mem_wr stay on
//      data request until accept; inst drops then re-requests -> no spurious inst_addr_ok.
//   6. mem_data_ok with FIFO empty -> no data_ok out, proto_err=1 and held; resetn=0 one cycle -> proto_err=0.

Source files
------------

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter: requester tags and
// the bundled command fields that travel from a requester to the memory port.
package sram_req_arbiter_pkg;

  localparam logic MST_INST = 1'b0;
  localparam logic MST_DATA = 1'b1;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SIZE_W = 2;
  localparam int STRB_W = 4;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [STRB_W-1:0] wstrb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_cmd_t;

endpackage

// File: rtl/sram_req_arbiter_order_fifo.sv
// In-order owner tag FIFO: one tag per accepted request, retired on each
// slave data_ok so responses can be steered back to whoever issued them.
module sram_req_arbiter_order_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_tag,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head_tag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0] tags;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign head_tag = tags[rd_ptr];

  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Tag storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      tags[wr_ptr] <= push_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch and load/store. Data
// wins by default, a starvation counter forces fetch through, responses are
// routed back in acceptance order.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [SIZE_W-1:0] inst_size,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [SIZE_W-1:0] data_size,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [SIZE_W-1:0] mem_size,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proto_err
);

  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

  logic          lock;
  logic          lock_owner;
  logic [SW-1:0] starve_cnt;
  logic          force_inst;
  logic          grant;
  logic          granted_req;
  logic          accept;
  logic          inst_accept;
  logic          fifo_full;
  logic          fifo_empty;
  logic          head_tag;
  logic          resp_valid;
  sram_cmd_t     inst_cmd;
  sram_cmd_t     data_cmd;
  sram_cmd_t     mem_cmd;

  assign inst_cmd = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                      addr: inst_addr, wdata: inst_wdata};
  assign data_cmd = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                      addr: data_addr, wdata: data_wdata};

  always_comb begin
    force_inst = inst_req & (starve_cnt == STARVE_MAX);
    if (lock) begin
      grant = lock_owner;
    end else if (data_req & ~force_inst) begin
      grant = MST_DATA;
    end else if (inst_req) begin
      grant = MST_INST;
    end else begin
      grant = MST_DATA;
    end
    granted_req = (grant == MST_DATA) ? data_req : inst_req;
    mem_cmd     = (grant == MST_DATA) ? data_cmd : inst_cmd;
  end

  // Handshake: a request transfers in the cycle where req and addr_ok are
  // both high; a response is valid only in the cycle data_ok is high, with
  // responses returned in the order their requests were accepted.
  assign mem_req     = granted_req & ~fifo_full;
  assign mem_wr      = mem_cmd.wr;
  assign mem_size    = mem_cmd.size;
  assign mem_wstrb   = mem_cmd.wstrb;
  assign mem_addr    = mem_cmd.addr;
  assign mem_wdata   = mem_cmd.wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_accept  = accept & (grant == MST_INST);
  assign inst_addr_ok = inst_accept;
  assign data_addr_ok = accept & (grant == MST_DATA);

  assign resp_valid   = mem_data_ok & ~fifo_empty;
  assign inst_data_ok = resp_valid & (head_tag == MST_INST);
  assign data_data_ok = resp_valid & (head_tag == MST_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Lock pins the grant while the slave stalls; it drops on accept or when
  // the owner withdraws, since mem_req is then low.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock       <= 1'b0;
      lock_owner <= MST_INST;
      starve_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      lock       <= mem_req & ~mem_addr_ok;
      lock_owner <= grant;
      if (!inst_req || inst_accept) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
      if (mem_data_ok & fifo_empty) begin
        proto_err <= 1'b1;
      end
    end
  end

  sram_req_arbiter_order_fifo #(
    .DEPTH (DEPTH)
  ) u_order_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (accept),
    .push_tag (grant),
    .pop      (mem_data_ok),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head_tag (head_tag)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference of the arbitration rules.
module tb_sram_req_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_LIM = 8;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;

  sram_req_arbiter #(.DEPTH(DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Slave behaviour knobs and its in-order response queue.
  bit          slave_ready, slave_hold, spur_ok;
  int          slave_lat;
  int          resp_due[$];
  logic [31:0] resp_data[$];
  logic [31:0] rdata_q[$];

  // Reference state: owners of outstanding requests, oldest first.
  logic [0:0] exp_q[$];
  int         m_starve;
  bit         m_locked;
  logic       m_lock_owner;
  logic       m_perr;

  logic        e_grant, e_mreq, e_acc, e_iaok, e_daok, e_idok, e_ddok, e_wr;
  logic [31:0] e_addr;

  task automatic model_reset();
    exp_q.delete();
    resp_due.delete();
    resp_data.delete();
    m_starve     = 0;
    m_locked     = 1'b0;
    m_lock_owner = 1'b0;
    m_perr       = 1'b0;
  endtask

  task automatic drive_idle();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
  endtask

  // Drive the slave side for this cycle, compute expectations, wait to mid-cycle.
  task automatic prep();
    bit force_i;
    mem_addr_ok = slave_ready;
    if (spur_ok) begin
      mem_data_ok = 1'b1; mem_rdata = $urandom;
    end else if (!slave_hold && resp_due.size() > 0 && resp_due[0] <= cyc) begin
      mem_data_ok = 1'b1; mem_rdata = resp_data[0];
    end else begin
      mem_data_ok = 1'b0; mem_rdata = $urandom;
    end
    force_i = inst_req && (m_starve == STARVE_LIM);
    if (m_locked)                  e_grant = m_lock_owner;
    else if (data_req && !force_i) e_grant = 1'b1;
    else if (inst_req)             e_grant = 1'b0;
    else                           e_grant = 1'b1;
    e_mreq = (e_grant ? data_req : inst_req) && (exp_q.size() < DEPTH);
    e_addr = e_grant ? data_addr : inst_addr;
    e_wr   = e_grant ? data_wr : inst_wr;
    e_acc  = e_mreq && slave_ready;
    e_iaok = e_acc && !e_grant;
    e_daok = e_acc && e_grant;
    e_idok = mem_data_ok && exp_q.size() > 0 && exp_q[0] == 1'b0;
    e_ddok = mem_data_ok && exp_q.size() > 0 && exp_q[0] == 1'b1;
    @(negedge clk);
  endtask

  // Apply what the coming clock edge does to the reference, then cross it.
  task automatic advance();
    if (mem_data_ok && !spur_ok && resp_due.size() > 0) begin
      void'(resp_due.pop_front());
      void'(resp_data.pop_front());
    end
    if (e_acc) begin
      resp_due.push_back(cyc + slave_lat);
      if (rdata_q.size() > 0) resp_data.push_back(rdata_q.pop_front());
      else                    resp_data.push_back($urandom);
    end
    if (!resetn) begin
      model_reset();
    end else begin
      if (mem_data_ok) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else                  m_perr = 1'b1;
      end
      if (e_acc) exp_q.push_back(e_grant);
      m_locked     = e_mreq && !slave_ready;
      m_lock_owner = e_grant;
      if (!inst_req || e_iaok)         m_starve = 0;
      else if (m_starve < STARVE_LIM)  m_starve++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    drive_idle();
    slave_hold = 0; slave_ready = 1; spur_ok = 0;
    for (int k = 0; k < 40 && resp_due.size() > 0; k++) begin
      prep();
      n_checks++;
      if ({inst_data_ok, data_data_ok, mem_req} !== {e_idok, e_ddok, 1'b0})
        $display("FAIL drain.ctl cyc=%0d got=%b exp=%b", cyc,
                 {inst_data_ok, data_data_ok, mem_req}, {e_idok, e_ddok, 1'b0});
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_reset();
    logic [109:0] outs;
    drive_idle();
    resetn = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    slave_ready = 0; slave_hold = 0; spur_ok = 0; slave_lat = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    outs = {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
            mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, proto_err, 4'h0};
    n_checks++;
    if (outs !== '0) $display("FAIL reset.during got=%h exp=0", outs);
    else n_pass++;
    @(posedge clk); #1;
    resetn = 1;
    @(negedge clk);
    outs = {inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
            mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, proto_err, 4'h0};
    n_checks++;
    if (outs !== '0 || mem_wdata !== '0) $display("FAIL reset.after got=%h exp=0", outs);
    else n_pass++;
    @(posedge clk); #1;
    cyc = 0;
  endtask

  task automatic test_single();
    slave_ready = 1; slave_lat = 2; rdata_q = {32'h0280_0000};
    inst_req = 1; inst_addr = 32'h1c00_0000; inst_size = 2'd2;
    for (int k = 0; k < 5; k++) begin
      prep();
      n_checks++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, proto_err} !==
          {e_iaok, e_daok, e_idok, e_ddok, e_mreq, m_perr})
        $display("FAIL single.ctl k=%0d got=%b exp=%b", k,
                 {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, proto_err},
                 {e_iaok, e_daok, e_idok, e_ddok, e_mreq, m_perr});
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (inst_addr_ok !== 1'b1 || mem_addr !== 32'h1c00_0000)
          $display("FAIL single.accept got ok=%b addr=%h exp ok=1 addr=1c000000", inst_addr_ok, mem_addr);
        else n_pass++;
      end
      if (k == 2) begin
        n_checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h0280_0000)
          $display("FAIL single.resp got ok=%b rdata=%h exp ok=1 rdata=02800000", inst_data_ok, inst_rdata);
        else n_pass++;
      end
      n_checks++;
      if (data_data_ok !== 1'b0) $display("FAIL single.no_data_ok k=%0d got=%b exp=0", k, data_data_ok);
      else n_pass++;
      advance();
      if (k == 0) inst_req = 0;
    end
  endtask

  task automatic test_priority();
    slave_ready = 1; slave_lat = 2; rdata_q = {32'hAAAA_0000, 32'h5555_0000};
    inst_req = 1; inst_addr = 32'h1c00_0040;
    data_req = 1; data_addr = 32'h0000_1000;
    for (int k = 0; k < 5; k++) begin
      prep();
      n_checks++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req} !==
          {e_iaok, e_daok, e_idok, e_ddok, e_mreq})
        $display("FAIL prio.ctl k=%0d got=%b exp=%b", k,
                 {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req},
                 {e_iaok, e_daok, e_idok, e_ddok, e_mreq});
      else n_pass++;
      if (k == 0) begin
        n_checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
          $display("FAIL prio.data_first got d/i=%b exp=10", {data_addr_ok, inst_addr_ok});
        else n_pass++;
      end
      if (k == 2) begin
        n_checks++;
        if (data_data_ok !== 1'b1 || inst_data_ok !== 1'b0 || data_rdata !== 32'hAAAA_0000)
          $display("FAIL prio.d_resp got ok=%b rdata=%h exp ok=1 rdata=aaaa0000", data_data_ok, data_rdata);
        else n_pass++;
      end
      if (k == 3) begin
        n_checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== 32'h5555_0000)
          $display("FAIL prio.i_resp got ok=%b rdata=%h exp ok=1 rdata=55550000", inst_data_ok, inst_rdata);
        else n_pass++;
      end
      advance();
      if (e_daok) data_req = 0;
      if (e_iaok) inst_req = 0;
    end
  endtask

  task automatic test_starve();
    slave_ready = 1; slave_lat = 1;
    inst_req = 1; inst_addr = 32'h1c00_0100; data_req = 1;
    for (int k = 0; k < 20; k++) begin
      data_addr = $urandom;
      prep();
      n_checks++;
      if (inst_addr_ok !== ((k == 8) || (k == 17)))
        $display("FAIL starve.inst_ok k=%0d got=%b exp=%b", k, inst_addr_ok, (k == 8) || (k == 17));
      else n_pass++;
      n_checks++;
      if ({data_addr_ok, inst_data_ok, data_data_ok} !== {e_daok, e_idok, e_ddok})
        $display("FAIL starve.ctl k=%0d got=%b exp=%b", k,
                 {data_addr_ok, inst_data_ok, data_data_ok}, {e_daok, e_idok, e_ddok});
      else n_pass++;
      advance();
    end
    drain();
  endtask

  task automatic test_full();
    slave_ready = 1; slave_lat = 1; data_req = 1; data_addr = $urandom;
    for (int k = 0; k < 8; k++) begin
      slave_hold = (k != 5);
      prep();
      n_checks++;
      if ({data_addr_ok, data_data_ok, mem_req} !== {e_daok, e_ddok, e_mreq})
        $display("FAIL full.ctl k=%0d got=%b exp=%b", k,
                 {data_addr_ok, data_data_ok, mem_req}, {e_daok, e_ddok, e_mreq});
      else n_pass++;
      if (k == 4) begin
        n_checks++;
        if (mem_req !== 1'b0 || data_addr_ok !== 1'b0)
          $display("FAIL full.blocked got req=%b ok=%b exp 0 0", mem_req, data_addr_ok);
        else n_pass++;
      end
      if (k == 5) begin
        n_checks++;
        if (data_data_ok !== 1'b1 || data_addr_ok !== 1'b0)
          $display("FAIL full.pop_no_push got dok=%b aok=%b exp 1 0", data_data_ok, data_addr_ok);
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if (data_addr_ok !== 1'b1) $display("FAIL full.next_accept got=%b exp=1", data_addr_ok);
        else n_pass++;
      end
      advance();
      if (e_daok) data_addr = $urandom;
      if (k == 6) data_req = 0;
    end
    drain();
  endtask

  task automatic test_lock();
    bit [7:0] rdy_t  = 8'b1001_1000;
    bit [7:0] inst_t = 8'b0011_1010;
    bit [7:0] data_t = 8'b1100_1111;
    slave_lat = 1;
    data_wr = 1; data_addr = 32'h0000_2468; data_wdata = 32'hdead_beef; data_wstrb = 4'hf;
    inst_addr = 32'h1c00_0200;
    for (int k = 0; k < 8; k++) begin
      slave_ready = rdy_t[k]; inst_req = inst_t[k]; data_req = data_t[k];
      prep();
      n_checks++;
      if ({inst_addr_ok, data_addr_ok, mem_req} !== {e_iaok, e_daok, e_mreq})
        $display("FAIL lock.ctl k=%0d got=%b exp=%b", k,
                 {inst_addr_ok, data_addr_ok, mem_req}, {e_iaok, e_daok, e_mreq});
      else n_pass++;
      if (k < 3) begin
        n_checks++;
        if (mem_addr !== 32'h0000_2468 || mem_wr !== 1'b1 || inst_addr_ok !== 1'b0)
          $display("FAIL lock.held k=%0d got addr=%h wr=%b iok=%b exp 00002468 1 0",
                   k, mem_addr, mem_wr, inst_addr_ok);
        else n_pass++;
      end
      if (k == 3) begin
        n_checks++;
        if ({data_addr_ok, inst_addr_ok} !== 2'b10)
          $display("FAIL lock.release got d/i=%b exp=10", {data_addr_ok, inst_addr_ok});
        else n_pass++;
      end
      if (k == 6) begin
        n_checks++;
        if ({mem_req, data_addr_ok} !== 2'b00)
          $display("FAIL lock.withdraw got req/dok=%b exp=00", {mem_req, data_addr_ok});
        else n_pass++;
      end
      advance();
    end
    drain();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      inst_req = ($urandom_range(0, 2) != 0); inst_wr = 1'($urandom_range(0, 1));
      inst_addr = $urandom; inst_size = 2'($urandom_range(0, 3));
      data_req = ($urandom_range(0, 2) != 0); data_wr = 1'($urandom_range(0, 1));
      data_addr = $urandom; data_wdata = $urandom; data_wstrb = 4'($urandom_range(0, 15));
      slave_ready = ($urandom_range(0, 3) != 0);
      slave_hold  = ($urandom_range(0, 4) == 0);
      slave_lat   = $urandom_range(1, 3);
      prep();
      n_checks++;
      if ({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, proto_err} !==
          {e_iaok, e_daok, e_idok, e_ddok, e_mreq, m_perr})
        $display("FAIL rand.ctl cyc=%0d got=%b exp=%b", cyc,
                 {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, proto_err},
                 {e_iaok, e_daok, e_idok, e_ddok, e_mreq, m_perr});
      else n_pass++;
      if (e_mreq) begin
        n_checks++;
        if (mem_addr !== e_addr || mem_wr !== e_wr)
          $display("FAIL rand.cmd cyc=%0d got addr=%h wr=%b exp addr=%h wr=%b",
                   cyc, mem_addr, mem_wr, e_addr, e_wr);
        else n_pass++;
      end
      if (mem_data_ok) begin
        n_checks++;
        if (inst_rdata !== mem_rdata || data_rdata !== mem_rdata)
          $display("FAIL rand.rdata cyc=%0d got i=%h d=%h exp=%h", cyc, inst_rdata, data_rdata, mem_rdata);
        else n_pass++;
      end
      advance();
    end
    drain();
  endtask

  task automatic test_proto();
    drive_idle();
    for (int k = 0; k < 4; k++) begin
      spur_ok = (k == 0);
      prep();
      n_checks++;
      if ({inst_data_ok, data_data_ok, proto_err} !== {1'b0, 1'b0, (k != 0)})
        $display("FAIL proto.sticky k=%0d got=%b exp=%b", k,
                 {inst_data_ok, data_data_ok, proto_err}, {1'b0, 1'b0, (k != 0)});
      else n_pass++;
      advance();
    end
    resetn = 0;
    prep(); advance();
    resetn = 1;
    prep();
    n_checks++;
    if (proto_err !== 1'b0) $display("FAIL proto.cleared got=%b exp=0", proto_err);
    else n_pass++;
    advance();
    // Leave a request outstanding, reset, then let the late response arrive.
    slave_ready = 1; slave_hold = 1; inst_req = 1; inst_addr = 32'h1c00_0300;
    prep(); advance();
    inst_req = 0; resetn = 0;
    prep(); advance();
    resetn = 1; spur_ok = 1;
    prep();
    n_checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b00)
      $display("FAIL proto.late_route got=%b exp=00", {inst_data_ok, data_data_ok});
    else n_pass++;
    advance();
    spur_ok = 0;
    prep();
    n_checks++;
    if (proto_err !== 1'b1) $display("FAIL proto.late_err got=%b exp=1", proto_err);
    else n_pass++;
    advance();
  endtask

  initial begin
    test_reset();
    test_single();
    drain();
    test_priority();
    drain();
    test_starve();
    test_full();
    test_lock();
    test_random();
    test_proto();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
